// File: rtl/corr_readout_ctrl.sv
// Run/readout sequencer for the five-bank multi-tau correlator: issues clr/start/stop pulses and streams all 992 bins framed by header and trailer.
// Latency: header 65 cycles after the stop pulse; each bin takes RD_LAT+1 cycles when m_ready is high.
// Backpressure: m_ready low stalls in HDR/OUT/TRL with m_data and ram_addr held; the core stays stopped meanwhile.
module corr_readout_ctrl #(
    parameter int          RD_LAT     = 2,
    parameter int          SETTLE_CYC = 64,
    parameter logic [15:0] HDR_TAG    = 16'hC0DE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_start,
    input  logic        dump_req,
    input  logic        restart_en,
    output logic        busy,
    output logic        corr_start,
    output logic        corr_stop,
    output logic        corr_clr,
    output logic        corr_read,
    output logic [15:0] ram_addr,
    input  logic [31:0] ram_data,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_STOP, S_SETTLE, S_HDR, S_WAIT, S_OUT, S_TRL, S_CLR, S_START
    } state_t;

    state_t        state;
    state_t        ret_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gap;        // cycles since the last control pulse, saturating
    logic          restart_q;
    logic          gap_ok;
    logic          xfer;
    logic [11:0]   last_off;

    // A pulse decided now lands next cycle, so SETTLE_CYC-1 elapsed cycles suffice.
    assign gap_ok   = (gap >= CW'(SETTLE_CYC - 1));
    assign xfer     = m_valid && m_ready;
    assign busy     = (state != S_IDLE);
    // Bank b holds 32<<(b-1) bins; bank number sits in the top address nibble.
    assign last_off = (12'd32 << (ram_addr[15:12] - 4'd1)) - 12'd1;

    // Sequencer: control pulses, settle timing, RAM sweep and stream framing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ret_state  <= S_IDLE;
            cnt        <= '0;
            gap        <= CW'(SETTLE_CYC);
            restart_q  <= 1'b0;
            corr_start <= 1'b0;
            corr_stop  <= 1'b0;
            corr_clr   <= 1'b0;
            corr_read  <= 1'b0;
            ram_addr   <= 16'h0000;
            m_data     <= 32'h0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_cnt  <= 16'h0000;
        end else begin
            corr_read  <= 1'b1;
            corr_start <= 1'b0;
            corr_stop  <= 1'b0;
            corr_clr   <= 1'b0;
            if (corr_start || corr_stop || corr_clr)
                gap <= CW'(1);
            else if (gap != CW'(SETTLE_CYC))
                gap <= gap + CW'(1);

            case (state)
                S_IDLE: begin
                    if (dump_req) begin
                        state     <= S_STOP;
                        restart_q <= restart_en;
                        corr_stop <= gap_ok;
                    end else if (run_start) begin
                        state     <= S_CLR;
                        restart_q <= 1'b1;
                        corr_clr  <= gap_ok;
                    end
                end
                // Pulse states wait here until the previous pulse is old enough.
                S_STOP: begin
                    if (corr_stop) begin
                        state     <= S_SETTLE;
                        ret_state <= S_HDR;
                        cnt       <= '0;
                    end else if (gap_ok) begin
                        corr_stop <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (corr_clr) begin
                        state     <= S_SETTLE;
                        ret_state <= S_START;
                        cnt       <= '0;
                    end else if (gap_ok) begin
                        corr_clr <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CW'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ret_state;
                        if (ret_state == S_HDR) begin
                            m_valid <= 1'b1;
                            m_data  <= {HDR_TAG, 16'd992};
                        end else begin
                            corr_start <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_START: state <= S_IDLE;
                S_HDR: begin
                    if (xfer) begin
                        m_valid  <= 1'b0;
                        ram_addr <= 16'h1000;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end
                end
                // ram_addr is stable here; data is valid on the final count.
                S_WAIT: begin
                    if (cnt == CW'(RD_LAT - 1)) begin
                        m_data  <= ram_data;
                        m_valid <= 1'b1;
                        state   <= S_OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_OUT: begin
                    if (xfer) begin
                        if (ram_addr == 16'h51FF) begin
                            m_data <= {frame_cnt, 16'h0000};
                            m_last <= 1'b1;
                            state  <= S_TRL;
                        end else begin
                            m_valid <= 1'b0;
                            cnt     <= '0;
                            state   <= S_WAIT;
                            if (ram_addr[11:0] == last_off)
                                ram_addr <= {ram_addr[15:12] + 4'd1, 12'h000};
                            else
                                ram_addr <= ram_addr + 16'd1;
                        end
                    end
                end
                S_TRL: begin
                    if (xfer) begin
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        if (restart_q) begin
                            state    <= S_CLR;
                            corr_clr <= gap_ok;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_readout_ctrl.sv
// Directed bench for corr_readout_ctrl: pulse timing, full-frame content, stalls, restart, request filtering, mid-sweep reset.
// Latency: RAM model answers RD_LAT=2 (one register stage after ram_addr).
// Backpressure: m_ready driven constant-high or random with a long hold-low window.
module tb_corr_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_start, dump_req, restart_en;
    logic        busy, corr_start, corr_stop, corr_clr, corr_read;
    logic [15:0] ram_addr;
    logic [31:0] ram_data;
    logic [31:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic [15:0] frame_cnt;

    corr_readout_ctrl #(.RD_LAT(2), .SETTLE_CYC(64), .HDR_TAG(16'hC0DE)) dut (
        .clk(clk), .rst(rst), .run_start(run_start), .dump_req(dump_req),
        .restart_en(restart_en), .busy(busy), .corr_start(corr_start),
        .corr_stop(corr_stop), .corr_clr(corr_clr), .corr_read(corr_read),
        .ram_addr(ram_addr), .ram_data(ram_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: data for an address appears one register stage later.
    logic [15:0] rd_addr = 16'h0;
    always @(posedge clk) rd_addr <= ram_addr;
    assign ram_data = {rd_addr, 16'h55AA};

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Observers
    logic [32:0] frame[$];
    int clr_cnt = 0, stop_cnt = 0, start_cnt = 0, last_cnt = 0;
    int clr_cyc = -1, stop_cyc = -1, start_cyc = -1, trl_cyc = -1, first_v = -1;
    int multi_err = 0, read_err = 0, stall_err = 0, stall_cyc = 0;
    logic        pv = 1'b0, px = 1'b0;
    logic [31:0] pd = '0;
    logic [15:0] pa = '0;

    always @(negedge clk) begin
        if (corr_clr)   begin clr_cnt++;   clr_cyc   = cyc; end
        if (corr_stop)  begin stop_cnt++;  stop_cyc  = cyc; end
        if (corr_start) begin start_cnt++; start_cyc = cyc; end
        if (int'(corr_clr) + int'(corr_stop) + int'(corr_start) > 1) multi_err++;
        if (!rst_q && !corr_read) read_err++;
        if (!rst_q && pv && !px) begin
            stall_cyc++;
            if (!m_valid || m_data !== pd || ram_addr !== pa) stall_err++;
        end
        if (m_valid && first_v < 0) first_v = cyc;
        if (m_valid && m_ready) begin
            frame.push_back({m_last, m_data});
            if (m_last) begin last_cnt++; trl_cyc = cyc; end
        end
        pv = m_valid; px = m_valid && m_ready; pd = m_data; pa = ram_addr;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] exp_word(input int i, input logic [15:0] fc);
        int j, b, sz;
        logic [15:0] a;
        if (i == 0)   return {1'b0, 32'hC0DE03E0};
        if (i == 993) return {1'b1, fc, 16'h0000};
        j = i - 1; b = 1; sz = 32;
        while (j >= sz) begin j -= sz; b++; sz *= 2; end
        a = 16'(b << 12) | 16'(j);
        return {1'b0, a, 16'h55AA};
    endfunction

    task automatic cmp_frame(input string name, input logic [15:0] fc);
        int bad = 0;
        chk({name, "_len"}, frame.size(), 994);
        if (frame.size() == 994)
            for (int i = 0; i < 994; i++)
                if (frame[i] !== exp_word(i, fc)) bad++;
        chk({name, "_bad_words"}, bad, 0);
    endtask

    // Runs one dump; returns once busy falls, or early when rst_at words have been seen.
    task automatic run_dump(input string name, input logic ren, input bit rnd, input bit with_start,
                            input int extra_at, input int rst_at, input int budget);
        bit done = 0, held = 0, extra_done = 0;
        int hold = 0;
        frame.delete();
        first_v = -1;
        @(posedge clk); #1;
        dump_req = 1'b1; restart_en = ren; run_start = with_start;
        @(posedge clk); #1;
        dump_req = 1'b0; run_start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rnd) begin
                if (!held && frame.size() >= 150) begin held = 1; hold = 500; end
                if (hold > 0) begin m_ready = 1'b0; hold--; end
                else m_ready = 1'($urandom_range(0, 1));
            end else begin
                m_ready = 1'b1;
            end
            dump_req = 1'b0;
            if (extra_at >= 0 && !extra_done && frame.size() == extra_at) begin
                dump_req = 1'b1; extra_done = 1;
            end
            if ((rst_at >= 0 && frame.size() >= rst_at) || !busy) begin done = 1; break; end
            @(posedge clk); #1;
        end
        dump_req = 1'b0; m_ready = 1'b1;
        chk({name, "_finished"}, done, 1);
    endtask

    typedef struct { int idx; logic [32:0] exp; } vec_t;
    vec_t vt[12];
    int c0, s0, p0, l0;

    initial begin
        vt[0]  = '{0,   {1'b0, 32'hC0DE03E0}};
        vt[1]  = '{1,   {1'b0, 32'h100055AA}};
        vt[2]  = '{32,  {1'b0, 32'h101F55AA}};
        vt[3]  = '{33,  {1'b0, 32'h200055AA}};
        vt[4]  = '{96,  {1'b0, 32'h203F55AA}};
        vt[5]  = '{97,  {1'b0, 32'h300055AA}};
        vt[6]  = '{224, {1'b0, 32'h307F55AA}};
        vt[7]  = '{225, {1'b0, 32'h400055AA}};
        vt[8]  = '{480, {1'b0, 32'h40FF55AA}};
        vt[9]  = '{481, {1'b0, 32'h500055AA}};
        vt[10] = '{992, {1'b0, 32'h51FF55AA}};
        vt[11] = '{993, {1'b1, 32'h00000000}};

        rst = 1'b1; run_start = 1'b0; dump_req = 1'b0; restart_en = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_read", corr_read, 0);
        chk("rst_pulses", {corr_start, corr_stop, corr_clr}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        chk("read_after_rst", corr_read, 1);

        // run_start: clr, settle, start
        run_start = 1'b1;
        @(posedge clk); #1; run_start = 1'b0;
        begin
            bit idle = 0;
            for (int k = 0; k < 300 && !idle; k++) begin
                @(posedge clk); #1;
                idle = !busy;
            end
            chk("run_finished", idle, 1);
        end
        chk("run_clr_cnt", clr_cnt, 1);
        chk("run_start_cnt", start_cnt, 1);
        chk("run_clr_to_start", start_cyc - clr_cyc, 65);
        chk("run_no_stop", stop_cnt, 0);

        // Plain dump, immediately after start: stop must wait out the pulse gap
        run_dump("dump1", 1'b0, 0, 0, -1, -1, 5000);
        chk("dump1_stop_cnt", stop_cnt, 1);
        chk("dump1_pulse_gap_ok", (stop_cyc - start_cyc) >= 64, 1);
        chk("dump1_stop_to_hdr", first_v - stop_cyc, 65);
        for (int i = 0; i < 12; i++)
            if (frame.size() > vt[i].idx)
                chk($sformatf("dump1_word%0d", vt[i].idx), {31'b0, frame[vt[i].idx][32]} ^ {frame[vt[i].idx][31:0]} ^ {vt[i].exp[31:0]} ^ {31'b0, vt[i].exp[32]}, 32'h0);
            else
                chk($sformatf("dump1_word%0d_missing", vt[i].idx), frame.size(), 994);
        cmp_frame("dump1", 16'h0000);
        chk("dump1_frame_cnt", frame_cnt, 1);

        // Dump with random backpressure and a 500-cycle hold mid bank 3
        stall_cyc = 0;
        run_dump("dump2", 1'b0, 1, 0, -1, -1, 20000);
        cmp_frame("dump2", 16'h0001);
        chk("dump2_frame_cnt", frame_cnt, 2);
        chk("dump2_stalled_long", stall_cyc >= 500, 1);

        // Restart after dump
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        c0 = clr_cnt; s0 = start_cnt;
        run_dump("dump3", 1'b1, 0, 0, -1, -1, 5000);
        cmp_frame("dump3", 16'h0000);
        chk("dump3_clr_once", clr_cnt - c0, 1);
        chk("dump3_start_once", start_cnt - s0, 1);
        chk("dump3_clr_to_start", start_cyc - clr_cyc, 65);
        chk("dump3_clr_after_trl", clr_cyc > trl_cyc, 1);
        run_dump("dump4", 1'b0, 0, 0, -1, -1, 5000);
        chk("dump4_trailer", frame.size() == 994 ? frame[993] : 33'h0, {1'b1, 32'h00010000});
        chk("dump4_frame_cnt", frame_cnt, 2);

        // Simultaneous dump+run_start, plus a dump during the sweep
        c0 = clr_cnt; s0 = start_cnt; l0 = last_cnt;
        run_dump("dump5", 1'b0, 0, 1, 100, -1, 5000);
        repeat (200) @(posedge clk);
        #1;
        cmp_frame("dump5", 16'h0002);
        chk("dump5_one_frame", last_cnt - l0, 1);
        chk("dump5_no_clr", clr_cnt - c0, 0);
        chk("dump5_no_start", start_cnt - s0, 0);
        chk("dump5_idle", busy, 0);
        chk("dump5_frame_cnt", frame_cnt, 3);

        // Reset mid-sweep at bin 300
        run_dump("dump6", 1'b0, 0, 0, -1, 301, 5000);
        c0 = clr_cnt; s0 = start_cnt; p0 = stop_cnt;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_pulses", (clr_cnt - c0) + (start_cnt - s0) + (stop_cnt - p0), 0);
        run_dump("dump7", 1'b0, 0, 0, -1, -1, 5000);
        cmp_frame("dump7", 16'h0000);
        chk("dump7_frame_cnt", frame_cnt, 1);

        chk("one_pulse_at_a_time", multi_err, 0);
        chk("corr_read_always_high", read_err, 0);
        chk("stall_stability", stall_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/corr_readout_ctrl.md
Name: corr_readout_ctrl

Overview:
- Run/readout sequencer for the five-bank multi-tau correlator core.
- Issues the core's start/stop/clear control pulses and freezes accumulation before a dump.
- Sweeps all 992 result bins through the core's 16-bit RAM read port and streams them out as one framed 32-bit stream with a valid/ready handshake.
- Optionally clears and restarts the measurement after the dump. Sits between the host/USB FIFO logic and the correlator core.

Parameters:
- RD_LAT, 2: cycles from ram_addr change to valid ram_data (1..7).
- SETTLE_CYC, 64: wait after any control pulse before the next action (at least 32, matching the core's 1/32-clk control rate limit).
- HDR_TAG, 16'hC0DE: upper half of the frame header word.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- run_start, in, 1: pulse; begin a fresh measurement (clear, then start).
- dump_req, in, 1: pulse; stop and read out all bins.
- restart_en, in, 1: sampled with dump_req; 1 = clear and restart after the dump.
- busy, out, 1: high in any state other than IDLE.
- corr_start, out, 1: one-cycle start pulse to the core.
- corr_stop, out, 1: one-cycle stop pulse to the core.
- corr_clr, out, 1: one-cycle clear pulse to the core.
- corr_read, out, 1: core read enable.
- ram_addr, out, 16: core result address.
- ram_data, in, 32: core result data.
- m_data, out, 32: stream data.
- m_valid, out, 1: stream valid.
- m_ready, in, 1: stream ready.
- m_last, out, 1: marks the trailer word.
- frame_cnt, out, 16: number of completed frames.

Behaviour:
- Reset values: state IDLE; all pulses 0; corr_read 0; ram_addr 0; m_valid 0; m_data 0; m_last 0; frame_cnt 0; busy 0.
- corr_read is 1 in every cycle after reset is released. A 0 would halt the core.
- Bank map: bank b=1..5 has 32<<(b-1) bins. ram_addr = {b[3:0], offset[11:0]}, with offset running 0..size-1. Sweep order: bank 1 offsets 0..31, bank 2 0..63, and so on through bank 5 0..511. Total 992 words.
- Frame layout, 994 words:
  - Header {HDR_TAG, 16'd992}.
  - 992 bin words, raw ram_data.
  - Trailer {frame_cnt_before_increment, 16'h0000} with m_last=1.
- States:
  - IDLE:
    - dump_req -> STOP; latch restart_en.
    - else run_start -> CLR; latch restart_en=1.
    - If both arrive in the same cycle, dump_req wins and run_start is dropped.
    - Requests arriving while busy are ignored (no queueing).
  - STOP: corr_stop=1 for exactly one cycle -> SETTLE, with next=HDR.
  - SETTLE: count SETTLE_CYC cycles -> next.
  - HDR: present the header word (m_valid=1) -> on m_valid&&m_ready, set ram_addr=0x1000 -> WAIT.
  - WAIT: count RD_LAT cycles with ram_addr stable -> OUT; capture ram_data into m_data on the final count.
  - OUT:
    - m_valid=1, holding m_data stable until m_ready.
    - On handshake, advance offset/bank and go to WAIT.
    - After bank 5 offset 511 -> TRL.
  - TRL:
    - Present the trailer with m_last=1.
    - On handshake, frame_cnt+1 (wraps 0xFFFF -> 0).
    - If restart latched -> CLR, else -> IDLE.
  - CLR: corr_clr=1 for one cycle -> SETTLE, with next=START.
  - START: corr_start=1 for one cycle -> IDLE.
- Handshake rules:
  - Transfer occurs on m_valid && m_ready.
  - m_valid never drops before a transfer.
  - Only one word is in flight; ram_addr never changes while m_valid=1.
  - Bin throughput is one word per RD_LAT+1 cycles at most.
- m_ready held low indefinitely: the controller stalls in OUT/HDR/TRL. The core stays stopped, so no data is corrupted.
- Never more than one of corr_start, corr_stop, corr_clr is high in a cycle. Successive pulses are separated by at least SETTLE_CYC cycles.
- Reset asserted mid-sweep:
  - Returns to IDLE on the next edge and drops m_valid.
  - No stop/clr/start pulse is emitted.
  - The core's state is left as-is.
  - frame_cnt resets to 0.

Test Plan:
- Reset, then run_start pulse -> corr_clr high in exactly 1 cycle; corr_start 1 cycle exactly 65 cycles later (SETTLE 64 + 1); busy low after; corr_read=1 throughout.
- dump_req with restart_en=0 and m_ready=1, using a RAM model returning {ram_addr,16'h55AA} with RD_LAT=2 -> corr_stop pulse; after 64 cycles the header 0xC0DE03E0; 992 words whose upper halves are 0x1000..0x101F, 0x2000..0x203F, ..., 0x5000..0x51FF; then trailer 0x00000000 with m_last; frame_cnt=1; total m_valid handshakes = 994.
- Same as the previous dump with m_ready toggled randomly and held low for 500 cycles mid-bank-3 -> identical 994-word sequence; m_data and ram_addr stable during every stall.
- Dump with restart_en=1 -> after the trailer, corr_clr then corr_start are each seen once, 65 cycles apart; second dump trailer = 0x00010000.
- dump_req and run_start in the same IDLE cycle, plus dump_req again during the sweep -> only one frame is produced and no corr_clr before the trailer.
- rst asserted at bin 300 -> next cycle m_valid=0, busy=0, frame_cnt=0; a following dump produces a full correct frame.
